repairmb_initiator: RTL and testbench
=====================================

Name: repairmb_initiator

Overview:
- Local-initiator half of the MBINIT.REPAIRMB sideband handshake. It is the requester that talks to the remote responder FSM.
- Sequence: sends start_req, then apply_degrade_req carrying the local functional-lane result, then end_req. After each request it waits for the matching response.
- Sits in the MBINIT LTSM after REVERSALMB, beside the responder. Both share the sideband TX arbiter and the RX decoder.
- Reports done or train-error to the MBINIT sequencer.

Parameters:
- TIMEOUT_CYCLES, 8000: max cycles spent waiting for any one response (8 ms at 1 MHz tick clock).
- RESEND_CYCLES, 1000: wait before apply_degrade_req is re-sent with no response.
- MAX_DEGRADE_TRIES, 2: total apply_degrade_req transmissions allowed.

Ports:
- CLK  in  1  block clock
- rst  in  1  asynchronous active-high reset
- i_MBINIT_REVERSALMB_end  in  1  enable; level-high while REPAIRMB is active
- i_Busy_SideBand  in  1  sideband TX busy
- i_falling_edge_busy  in  1  one-cycle pulse: current TX message finished
- i_RX_SbMessage  in  4  decoded RX message code
- i_msg_valid  in  1  i_RX_SbMessage valid this cycle
- i_Local_Lanes  in  2  local lane test result: 11=x16, 01=lanes 0-7, 10=lanes 8-15, 00=none
- o_TX_SbMessage  out  4  TX message code
- o_ValidOutData  out  1  one-cycle TX request strobe
- o_Functional_Lanes  out  2  msginfo for apply_degrade_req; also latched lane map for width-degrade logic
- o_MBINIT_REPAIRMB_end  out  1  high in DONE
- o_train_error  out  1  high in ERROR

Behaviour:
- Message codes:
  - start_req 0001, start_resp 0010
  - end_req 0011, end_resp 0100
  - apply_degrade_req 0101, apply_degrade_resp 0110
- Reset values: o_TX_SbMessage=0000, o_ValidOutData=0, o_Functional_Lanes=11, o_MBINIT_REPAIRMB_end=0, o_train_error=0. FSM=IDLE, counters=0.
- All outputs are registered and decoded from next state. A strobe therefore appears in the cycle after the transition decision.
- From any non-IDLE state, enable low returns the FSM to IDLE next cycle. At the same edge all outputs except o_Functional_Lanes take their reset values, and counters clear.
- States and transitions:
  - IDLE: enable high -> BUSY_START.
  - BUSY_START: ~i_Busy_SideBand -> SEND_START. On entry, o_ValidOutData=1 for one cycle and o_TX_SbMessage=0001.
  - SEND_START: i_falling_edge_busy -> WAIT_START.
  - WAIT_START: i_msg_valid && code==0010 -> EVAL. Timeout -> ERROR.
  - EVAL (1 cycle): latch o_Functional_Lanes<=i_Local_Lanes. If i_Local_Lanes==00 -> ERROR without sending; else -> BUSY_DEG.
  - BUSY_DEG: ~busy -> SEND_DEG. Strobe with code 0101; try counter increments.
  - SEND_DEG: falling edge -> WAIT_DEG.
  - WAIT_DEG: valid && code==0110 -> BUSY_END.
    - When the resend counter reaches RESEND_CYCLES: if tries<MAX_DEGRADE_TRIES -> BUSY_DEG, else keep waiting.
    - Timeout -> ERROR.
  - BUSY_END -> SEND_END (code 0011) -> WAIT_END. valid && code==0100 -> DONE. Timeout -> ERROR.
  - DONE: hold o_MBINIT_REPAIRMB_end=1 until enable drops.
  - ERROR: hold o_train_error=1 until enable drops.
- Wait counters:
  - Timeout counter width = $clog2(TIMEOUT_CYCLES+1). It clears on entry to every WAIT_* state and increments each cycle in WAIT_*.
  - Timeout fires when the count equals TIMEOUT_CYCLES-1, so the response window is exactly TIMEOUT_CYCLES cycles.
  - The resend counter clears on entry to WAIT_DEG.
- Message filtering:
  - A valid message with any other code in a WAIT_* state is ignored; the counter keeps running.
  - Messages arriving outside WAIT_* states are ignored.
- Edge cases:
  - Response and timeout in the same cycle: the response wins.
  - Busy already low on entry to BUSY_*: the strobe is issued the next cycle, with no extra wait.
- o_Functional_Lanes holds its last value across IDLE; only reset restores it to 11.

Test Plan:
- Happy path:
  - Stimulus: enable=1, busy=0, i_Local_Lanes=11. Each falling_edge pulse arrives 3 cycles after its strobe; responders return 0010, 0110, 0100.
  - Required: TX strobes with codes 0001, 0101, 0011 in that order; o_Functional_Lanes=11; o_MBINIT_REPAIRMB_end=1 and stays high.
- Degraded width:
  - Stimulus: i_Local_Lanes=01.
  - Required: apply_degrade_req sent with o_Functional_Lanes=01; completes DONE.
- No lanes:
  - Stimulus: i_Local_Lanes=00 after start_resp.
  - Required: no 0101 strobe; o_train_error=1 in the cycle after EVAL.
- Resend:
  - Stimulus: withhold 0110 for RESEND_CYCLES, then return 0110 after the 2nd request.
  - Required: exactly two 0101 strobes, then end_req.
  - Variant: withhold 0110 entirely. Required: o_train_error asserts TIMEOUT_CYCLES after WAIT_DEG entry.
- Wrong code and disable:
  - Stimulus: inject code 0100 during WAIT_START. Required: ignored, FSM stays in WAIT_START.
  - Stimulus: drop enable mid-WAIT_DEG. Required: IDLE next cycle, all strobes 0.
  - Stimulus: assert rst mid-SEND_DEG. Required: asynchronous return of all outputs to reset values.

Source files
------------

// File: rtl/repairmb_initiator.sv
// MBINIT.REPAIRMB local initiator: drives the start / apply_degrade / end
// request sequence over the sideband and waits for each matching response.
// Every output is registered and decoded from the next state.
module repairmb_initiator #(
    parameter int TIMEOUT_CYCLES    = 8000,
    parameter int RESEND_CYCLES     = 1000,
    parameter int MAX_DEGRADE_TRIES = 2
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       i_MBINIT_REVERSALMB_end,
    input  logic       i_Busy_SideBand,
    input  logic       i_falling_edge_busy,
    input  logic [3:0] i_RX_SbMessage,
    input  logic       i_msg_valid,
    input  logic [1:0] i_Local_Lanes,
    output logic [3:0] o_TX_SbMessage,
    output logic       o_ValidOutData,
    output logic [1:0] o_Functional_Lanes,
    output logic       o_MBINIT_REPAIRMB_end,
    output logic       o_train_error
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RS_W = $clog2(RESEND_CYCLES + 1);
    localparam int TR_W = $clog2(MAX_DEGRADE_TRIES + 1);

    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RS_W-1:0] RS_LAST   = RS_W'(RESEND_CYCLES - 1);
    localparam logic [TR_W-1:0] TRIES_MAX = TR_W'(MAX_DEGRADE_TRIES);

    localparam logic [3:0] START_REQ  = 4'b0001;
    localparam logic [3:0] START_RESP = 4'b0010;
    localparam logic [3:0] END_REQ    = 4'b0011;
    localparam logic [3:0] END_RESP   = 4'b0100;
    localparam logic [3:0] DEG_REQ    = 4'b0101;
    localparam logic [3:0] DEG_RESP   = 4'b0110;

    typedef enum logic [3:0] {
        IDLE,
        BUSY_START,
        SEND_START,
        WAIT_START,
        EVAL,
        BUSY_DEG,
        SEND_DEG,
        WAIT_DEG,
        BUSY_END,
        SEND_END,
        WAIT_END,
        DONE,
        ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [RS_W-1:0] rs_cnt_q, rs_cnt_d;
    logic [TR_W-1:0] tries_q, tries_d;
    logic [3:0]      tx_msg_q, tx_msg_d;
    logic            valid_q, valid_d;
    logic [1:0]      lanes_q, lanes_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            enable;
    logic            timed_out;

    assign enable    = i_MBINIT_REVERSALMB_end;
    assign timed_out = (to_cnt_q == TO_LAST);

    // State, counters and registered outputs.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            rs_cnt_q <= '0;
            tries_q  <= '0;
            tx_msg_q <= '0;
            valid_q  <= 1'b0;
            lanes_q  <= 2'b11;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            rs_cnt_q <= rs_cnt_d;
            tries_q  <= tries_d;
            tx_msg_q <= tx_msg_d;
            valid_q  <= valid_d;
            lanes_q  <= lanes_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state decision, then outputs and counters decoded from it.
    always_comb begin
        state_d  = state_q;
        to_cnt_d = '0;
        rs_cnt_d = '0;
        tries_d  = tries_q;
        tx_msg_d = tx_msg_q;
        valid_d  = 1'b0;
        lanes_d  = lanes_q;

        if (state_q != IDLE && !enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:       if (enable) state_d = BUSY_START;
                BUSY_START: if (!i_Busy_SideBand) state_d = SEND_START;
                SEND_START: if (i_falling_edge_busy) state_d = WAIT_START;
                WAIT_START: begin
                    if (i_msg_valid && i_RX_SbMessage == START_RESP) state_d = EVAL;
                    else if (timed_out)                              state_d = ERROR;
                end
                EVAL: begin
                    lanes_d = i_Local_Lanes;
                    state_d = (i_Local_Lanes == 2'b00) ? ERROR : BUSY_DEG;
                end
                BUSY_DEG:   if (!i_Busy_SideBand) state_d = SEND_DEG;
                SEND_DEG:   if (i_falling_edge_busy) state_d = WAIT_DEG;
                // Response beats timeout, timeout beats a resend.
                WAIT_DEG: begin
                    if (i_msg_valid && i_RX_SbMessage == DEG_RESP) state_d = BUSY_END;
                    else if (timed_out)                            state_d = ERROR;
                    else if (rs_cnt_q == RS_LAST && tries_q < TRIES_MAX)
                                                                   state_d = BUSY_DEG;
                end
                BUSY_END:   if (!i_Busy_SideBand) state_d = SEND_END;
                SEND_END:   if (i_falling_edge_busy) state_d = WAIT_END;
                WAIT_END: begin
                    if (i_msg_valid && i_RX_SbMessage == END_RESP) state_d = DONE;
                    else if (timed_out)                            state_d = ERROR;
                end
                DONE:       state_d = DONE;
                ERROR:      state_d = ERROR;
                default:    state_d = IDLE;
            endcase
        end

        // Request strobes fire on the BUSY_* -> SEND_* transition.
        if (state_q == BUSY_START && state_d == SEND_START) begin
            valid_d  = 1'b1;
            tx_msg_d = START_REQ;
        end
        if (state_q == BUSY_DEG && state_d == SEND_DEG) begin
            valid_d  = 1'b1;
            tx_msg_d = DEG_REQ;
            tries_d  = tries_q + 1'b1;
        end
        if (state_q == BUSY_END && state_d == SEND_END) begin
            valid_d  = 1'b1;
            tx_msg_d = END_REQ;
        end

        // Counters run only while staying in a WAIT_* state; entry clears them.
        if (state_d == state_q &&
            (state_q == WAIT_START || state_q == WAIT_DEG || state_q == WAIT_END)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (state_d == WAIT_DEG && state_q == WAIT_DEG) begin
            rs_cnt_d = (rs_cnt_q == RS_LAST) ? rs_cnt_q : rs_cnt_q + 1'b1;
        end

        if (state_d == IDLE) begin
            tx_msg_d = '0;
            tries_d  = '0;
        end

        done_d = (state_d == DONE);
        err_d  = (state_d == ERROR);
    end

    assign o_TX_SbMessage        = tx_msg_q;
    assign o_ValidOutData        = valid_q;
    assign o_Functional_Lanes    = lanes_q;
    assign o_MBINIT_REPAIRMB_end = done_q;
    assign o_train_error         = err_q;

endmodule

// File: tb/tb_repairmb_initiator.sv
// Directed bench for repairmb_initiator with shortened wait parameters.
module tb_repairmb_initiator;

    localparam int T = 40;
    localparam int R = 10;

    logic       CLK = 1'b0;
    logic       rst;
    logic       en;
    logic       busy;
    logic       fe;
    logic [3:0] msg;
    logic       mv;
    logic [1:0] ll;
    logic [3:0] o_TX_SbMessage;
    logic       o_ValidOutData;
    logic [1:0] o_Functional_Lanes;
    logic       o_MBINIT_REPAIRMB_end;
    logic       o_train_error;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int deg_cnt = 0;
    int d0;

    repairmb_initiator #(
        .TIMEOUT_CYCLES   (T),
        .RESEND_CYCLES    (R),
        .MAX_DEGRADE_TRIES(2)
    ) dut (
        .CLK                    (CLK),
        .rst                    (rst),
        .i_MBINIT_REVERSALMB_end(en),
        .i_Busy_SideBand        (busy),
        .i_falling_edge_busy    (fe),
        .i_RX_SbMessage         (msg),
        .i_msg_valid            (mv),
        .i_Local_Lanes          (ll),
        .o_TX_SbMessage         (o_TX_SbMessage),
        .o_ValidOutData         (o_ValidOutData),
        .o_Functional_Lanes     (o_Functional_Lanes),
        .o_MBINIT_REPAIRMB_end  (o_MBINIT_REPAIRMB_end),
        .o_train_error          (o_train_error)
    );

    always #5 CLK = ~CLK;

    // Count apply_degrade_req strobes.
    always @(negedge CLK) begin
        if (rst === 1'b0 && o_ValidOutData === 1'b1 && o_TX_SbMessage === 4'b0101)
            deg_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_strobe(input string tag, input int budget);
        int n = 0;
        while (o_ValidOutData !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, " strobe"}, {3'b0, o_ValidOutData}, 4'b0001);
    endtask

    // Wait for a request strobe, check its code, end the TX 3 cycles later.
    task automatic send_phase(input string tag, input logic [3:0] code);
        wait_strobe(tag, 20);
        check({tag, " code"}, o_TX_SbMessage, code);
        repeat (3) tick();
        fe = 1'b1;
        tick();
        fe = 1'b0;
    endtask

    task automatic respond(input logic [3:0] code);
        msg = code;
        mv  = 1'b1;
        tick();
        mv  = 1'b0;
        msg = 4'b0000;
    endtask

    task automatic disable_run(input string tag);
        en = 1'b0;
        tick();
        check({tag, " idle valid"}, {3'b0, o_ValidOutData}, 4'b0000);
        check({tag, " idle tx"}, o_TX_SbMessage, 4'b0000);
        check({tag, " idle end"}, {3'b0, o_MBINIT_REPAIRMB_end}, 4'b0000);
        check({tag, " idle err"}, {3'b0, o_train_error}, 4'b0000);
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; busy = 1'b0; fe = 1'b0; mv = 1'b0; msg = 4'b0000; ll = 2'b11;
        tick(); tick();
        check("rst tx", o_TX_SbMessage, 4'b0000);
        check("rst valid", {3'b0, o_ValidOutData}, 4'b0000);
        check("rst lanes", {2'b0, o_Functional_Lanes}, 4'b0011);
        check("rst end", {3'b0, o_MBINIT_REPAIRMB_end}, 4'b0000);
        check("rst err", {3'b0, o_train_error}, 4'b0000);
        rst = 1'b0;
        tick();

        // Happy path, x16
        d0 = deg_cnt;
        ll = 2'b11; en = 1'b1;
        tick();
        check("hp no early strobe", {3'b0, o_ValidOutData}, 4'b0000);
        tick();
        check("hp start strobe latency", {3'b0, o_ValidOutData}, 4'b0001);
        send_phase("hp start", 4'b0001);
        respond(4'b0010);
        send_phase("hp deg", 4'b0101);
        check("hp lanes", {2'b0, o_Functional_Lanes}, 4'b0011);
        respond(4'b0110);
        send_phase("hp end", 4'b0011);
        respond(4'b0100);
        check("hp done", {3'b0, o_MBINIT_REPAIRMB_end}, 4'b0001);
        repeat (5) tick();
        check("hp done held", {3'b0, o_MBINIT_REPAIRMB_end}, 4'b0001);
        check("hp no err", {3'b0, o_train_error}, 4'b0000);
        check("hp one deg", 4'(deg_cnt - d0), 4'd1);
        disable_run("hp");

        // Degraded width, lanes 0-7
        ll = 2'b01; en = 1'b1;
        send_phase("dg start", 4'b0001);
        respond(4'b0010);
        send_phase("dg deg", 4'b0101);
        respond(4'b0110);
        send_phase("dg end", 4'b0011);
        respond(4'b0100);
        check("dg done", {3'b0, o_MBINIT_REPAIRMB_end}, 4'b0001);
        check("dg lanes", {2'b0, o_Functional_Lanes}, 4'b0001);
        disable_run("dg");
        check("dg lanes held in idle", {2'b0, o_Functional_Lanes}, 4'b0001);

        // No functional lanes
        d0 = deg_cnt;
        ll = 2'b00; en = 1'b1;
        send_phase("nl start", 4'b0001);
        respond(4'b0010);
        check("nl err not yet", {3'b0, o_train_error}, 4'b0000);
        tick();
        check("nl err", {3'b0, o_train_error}, 4'b0001);
        check("nl lanes", {2'b0, o_Functional_Lanes}, 4'b0000);
        repeat (4) tick();
        check("nl no deg", 4'(deg_cnt - d0), 4'd0);
        check("nl err held", {3'b0, o_train_error}, 4'b0001);
        disable_run("nl");

        // Resend, answered after second request
        d0 = deg_cnt;
        ll = 2'b10; en = 1'b1;
        send_phase("rs start", 4'b0001);
        respond(4'b0010);
        send_phase("rs deg1", 4'b0101);
        repeat (R) tick();
        check("rs no early resend", {3'b0, o_ValidOutData}, 4'b0000);
        tick();
        check("rs resend latency", {3'b0, o_ValidOutData}, 4'b0001);
        send_phase("rs deg2", 4'b0101);
        respond(4'b0110);
        send_phase("rs end", 4'b0011);
        respond(4'b0100);
        check("rs done", {3'b0, o_MBINIT_REPAIRMB_end}, 4'b0001);
        check("rs two degs", 4'(deg_cnt - d0), 4'd2);
        check("rs lanes", {2'b0, o_Functional_Lanes}, 4'b0010);
        disable_run("rs");

        // Resend, never answered: timeout after last WAIT_DEG entry
        d0 = deg_cnt;
        ll = 2'b11; en = 1'b1;
        send_phase("to start", 4'b0001);
        respond(4'b0010);
        send_phase("to deg1", 4'b0101);
        repeat (R + 1) tick();
        send_phase("to deg2", 4'b0101);
        repeat (T - 1) tick();
        check("to err not yet", {3'b0, o_train_error}, 4'b0000);
        tick();
        check("to err", {3'b0, o_train_error}, 4'b0001);
        check("to two degs", 4'(deg_cnt - d0), 4'd2);
        check("to no done", {3'b0, o_MBINIT_REPAIRMB_end}, 4'b0000);
        disable_run("to");

        // Wrong code in WAIT_START, then enable drop in WAIT_DEG
        ll = 2'b11; en = 1'b1;
        send_phase("wc start", 4'b0001);
        respond(4'b0100);
        repeat (3) tick();
        check("wc ignored valid", {3'b0, o_ValidOutData}, 4'b0000);
        check("wc ignored err", {3'b0, o_train_error}, 4'b0000);
        respond(4'b0010);
        tick();
        tick();
        check("wc still waited deg strobe", {3'b0, o_ValidOutData}, 4'b0001);
        send_phase("wc deg", 4'b0101);
        repeat (3) tick();
        en = 1'b0;
        tick();
        check("dis valid", {3'b0, o_ValidOutData}, 4'b0000);
        check("dis tx", o_TX_SbMessage, 4'b0000);
        check("dis err", {3'b0, o_train_error}, 4'b0000);
        check("dis lanes kept", {2'b0, o_Functional_Lanes}, 4'b0011);
        repeat (3) tick();
        check("dis stays idle", {3'b0, o_ValidOutData}, 4'b0000);

        // Asynchronous reset in SEND_DEG
        ll = 2'b01; en = 1'b1;
        send_phase("ar start", 4'b0001);
        respond(4'b0010);
        wait_strobe("ar deg", 20);
        check("ar lanes before", {2'b0, o_Functional_Lanes}, 4'b0001);
        tick();
        check("ar tx before", o_TX_SbMessage, 4'b0101);
        #2 rst = 1'b1;
        #1;
        check("ar tx", o_TX_SbMessage, 4'b0000);
        check("ar valid", {3'b0, o_ValidOutData}, 4'b0000);
        check("ar lanes", {2'b0, o_Functional_Lanes}, 4'b0011);
        check("ar end", {3'b0, o_MBINIT_REPAIRMB_end}, 4'b0000);
        check("ar err", {3'b0, o_train_error}, 4'b0000);
        en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("ar idle after", {3'b0, o_ValidOutData}, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
